alu_exec_stage: RTL and testbench
=================================

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 SHALL have parameter DW, default 16, datapath width.
REQ-002 SHALL have parameter AW, default 3, register address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 instr_valid  input  1  instruction offered.
REQ-006 instr_ready  output  1  block accepts instruction this cycle.
REQ-007 opcode  input  3  operation select.
REQ-008 dst / srcA / srcB  input  AW each  destination and source register addresses.
REQ-009 rdAddrA / rdAddrB  output  AW each  register-file read addresses.
REQ-010 rdDataA / rdDataB  input  DW each  register-file read data, combinational from rdAddr.
REQ-011 write  output  1  register-file write strobe.
REQ-012 wrAddr  output  AW  write address; wrData  output  DW  write data.
REQ-013 busy  output  1  high in every non-IDLE state.
REQ-014 zero / carry  output  1 each  result flags of last retired instruction.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, MUL, WB.
REQ-016 IDLE: instr_ready=1; on instr_valid&instr_ready latch opcode, dst, srcA, srcB -> EXEC; else stay.
REQ-017 instr_ready SHALL be 0 in EXEC, MUL, WB; valid without ready SHALL be ignored.
REQ-018 rdAddrA/rdAddrB SHALL equal latched srcA/srcB.
REQ-019 EXEC: sample rdDataA/B; opcode 6 -> MUL, all others -> WB with result registered.
REQ-020 Opcodes: 0 ADD A+B; 1 SUB A-B; 2 AND; 3 OR; 4 XOR; 5 SHL A<<B[3:0]; 6 MUL low DW bits of A*B; 7 PASS A.
REQ-021 All results SHALL be truncated to DW bits, modulo 2^DW wrap.
REQ-022 carry: ADD carry-out bit DW; SUB 1 when A<B unsigned; 0 for all other opcodes.
REQ-023 zero SHALL be 1 when registered result equals 0.
REQ-024 MUL: iterative shift-add, exactly 16 cycles in MUL, then -> WB.
REQ-025 WB: write=1, wrAddr=latched dst, wrData=result, for exactly one cycle; zero/carry update at the WB edge; -> IDLE.
REQ-026 Latency: instruction accepted at edge N -> write high in cycle after edge N+2 (non-MUL) or N+18 (MUL).
REQ-027 Throughput: one instruction per 3 cycles (non-MUL), per 19 cycles (MUL).
REQ-028 Next read SHALL occur only after prior WB edge; read-after-write to same register SHALL return new value without forwarding.
REQ-029 dst in 4..7 SHALL still produce a WB cycle; the register file discards it.
REQ-030 srcA/srcB in 4..7 read as 0; block SHALL treat them as operand 0.

Reset
REQ-031 rst high SHALL force IDLE next edge from any state, aborting any in-flight instruction with no write.
REQ-032 Reset values: write=0, wrAddr=0, wrData=0, busy=0, zero=0, carry=0, latched srcA/srcB/dst/opcode=0, MUL counter=0.
REQ-033 instr_ready SHALL be 0 while rst is high.

Structure
REQ-034 Shared package alu_exec_pkg SHALL hold opcode constants, FSM state encoding, DW/AW defaults.
REQ-035 Iterative multiplier SHALL be sub-module seq_mul16 (start, operands in, 16-cycle done pulse, product low DW bits).
REQ-036 Register file is external; this block drives its ports directly.

Verification
REQ-037 Reset, then ADD r1=0x0003, r2=0x0005, dst r3 -> write on cycle 3, wrAddr=3, wrData=0x0008, zero=0, carry=0.
REQ-038 ADD 0xFFFF+0x0001 -> wrData=0x0000, zero=1, carry=1; SUB 0x0002-0x0005 -> wrData=0xFFFD, carry=1.
REQ-039 MUL 0x0012*0x0034 -> wrData=0x03A8 exactly 18 cycles after accept; instr_ready=0 throughout.
REQ-040 Back-to-back: write r1=7 then ADD r1+r1 -> second wrData=0x000E, no stale read.
REQ-041 rst asserted mid-MUL (cycle 8) -> write never asserts, IDLE next edge, instr_ready=1 after rst release.
REQ-042 SHL 0x8001 by B=0x0001 -> wrData=0x0002, carry=0; srcB=5 (unmapped) with ADD -> wrData equals A.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// Shared definitions for the ALU execute stage: default widths, opcode
// values, FSM state encoding and multiplier iteration count.
package alu_exec_pkg;

    localparam int DW_DEF     = 16;  // datapath width
    localparam int AW_DEF     = 3;   // register address width
    localparam int NUM_REGS   = 4;   // registers actually backed by the register file
    localparam int MUL_CYCLES = 16;  // cycles spent in the iterative multiplier

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_SHL  = 3'd5,
        OP_MUL  = 3'd6,
        OP_PASS = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_WB   = 2'd3
    } state_e;

endpackage

// File: rtl/seq_mul16.sv
// Iterative shift-add multiplier. Operands load on start_i, one partial
// product is accumulated per cycle, and done_o is raised during the 16th
// cycle with product_o already including that final step, so the caller
// can capture the low DW bits on the same edge it leaves its wait state.
module seq_mul16
    import alu_exec_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic          done_o,
    output logic [DW-1:0] product_o
);

    logic [DW-1:0] mcand_q;
    logic [DW-1:0] mplier_q;
    logic [DW-1:0] acc_q;
    logic [3:0]    cnt_q;
    logic          run_q;
    logic [DW-1:0] step_sum;

    // Accumulator plus the partial product selected by the current multiplier LSB.
    always_comb begin
        step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    assign done_o    = run_q && (cnt_q == 4'(MUL_CYCLES - 1));
    assign product_o = step_sum;

    // Load operands on start, then shift multiplicand left / multiplier right each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (start_i) begin
            mcand_q  <= a_i;
            mplier_q <= b_i;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b1;
        end else if (run_q) begin
            acc_q    <= step_sum;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 4'd1;
            if (cnt_q == 4'(MUL_CYCLES - 1)) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Single-issue ALU execute stage: accepts one instruction at a time, reads
// two operands from an external register file, computes the result (MUL via
// the iterative multiplier) and writes it back with registered strobes.
module alu_exec_stage
    import alu_exec_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [2:0]    opcode,
    input  logic [AW-1:0] dst,
    input  logic [AW-1:0] srcA,
    input  logic [AW-1:0] srcB,
    output logic [AW-1:0] rdAddrA,
    output logic [AW-1:0] rdAddrB,
    input  logic [DW-1:0] rdDataA,
    input  logic [DW-1:0] rdDataB,
    output logic          write,
    output logic [AW-1:0] wrAddr,
    output logic [DW-1:0] wrData,
    output logic          busy,
    output logic          zero,
    output logic          carry
);

    localparam logic [AW:0] NUM_REGS_W = (AW + 1)'(NUM_REGS);

    state_e        state_q, state_d;
    logic [2:0]    opcode_q;
    logic [AW-1:0] dst_q, srca_q, srcb_q;
    logic [DW-1:0] result_q;
    logic          res_carry_q;
    logic          write_q;
    logic [AW-1:0] wr_addr_q;
    logic [DW-1:0] wr_data_q;
    logic          zero_q, carry_q;

    logic [DW-1:0] op_a, op_b;
    logic [DW:0]   sum_ext;
    logic [DW-1:0] alu_res;
    logic          alu_carry;
    logic          accept;
    logic          mul_start;
    logic          mul_done;
    logic [DW-1:0] mul_product;

    assign instr_ready = (state_q == ST_IDLE) && !rst;
    assign accept      = instr_valid && instr_ready;
    assign busy        = (state_q != ST_IDLE);
    assign rdAddrA     = srca_q;
    assign rdAddrB     = srcb_q;
    assign write       = write_q;
    assign wrAddr      = wr_addr_q;
    assign wrData      = wr_data_q;
    assign zero        = zero_q;
    assign carry       = carry_q;

    // Unbacked register addresses are forced to operand 0 regardless of read data.
    assign op_a    = ({1'b0, srca_q} < NUM_REGS_W) ? rdDataA : '0;
    assign op_b    = ({1'b0, srcb_q} < NUM_REGS_W) ? rdDataB : '0;
    assign sum_ext = {1'b0, op_a} + {1'b0, op_b};

    // Single-cycle ALU result and carry for every opcode except MUL.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (opcode_e'(opcode_q))
            OP_ADD: begin
                alu_res   = sum_ext[DW-1:0];
                alu_carry = sum_ext[DW];
            end
            OP_SUB: begin
                alu_res   = op_a - op_b;
                alu_carry = (op_a < op_b);
            end
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SHL:  alu_res = op_a << op_b[3:0];
            OP_PASS: alu_res = op_a;
            default: alu_res = '0;
        endcase
    end

    // Next-state logic; MUL start is pulsed on the EXEC->MUL transition.
    always_comb begin
        state_d   = state_q;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: begin
                if (opcode_q == OP_MUL) begin
                    state_d   = ST_MUL;
                    mul_start = 1'b1;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MUL:  if (mul_done) state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset aborts any in-flight instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction latch, result capture and registered write-back outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            opcode_q    <= '0;
            dst_q       <= '0;
            srca_q      <= '0;
            srcb_q      <= '0;
            result_q    <= '0;
            res_carry_q <= 1'b0;
            write_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
        end else begin
            write_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        opcode_q <= opcode;
                        dst_q    <= dst;
                        srca_q   <= srcA;
                        srcb_q   <= srcB;
                    end
                end
                ST_EXEC: begin
                    if (opcode_q != OP_MUL) begin
                        result_q    <= alu_res;
                        res_carry_q <= alu_carry;
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        result_q    <= mul_product;
                        res_carry_q <= 1'b0;
                    end
                end
                ST_WB: begin
                    write_q   <= 1'b1;
                    wr_addr_q <= dst_q;
                    wr_data_q <= result_q;
                    zero_q    <= (result_q == '0);
                    carry_q   <= res_carry_q;
                end
                default: ;
            endcase
        end
    end

    seq_mul16 #(
        .DW(DW)
    ) u_mul (
        .clk      (clk),
        .rst      (rst),
        .start_i  (mul_start),
        .a_i      (op_a),
        .b_i      (op_b),
        .done_o   (mul_done),
        .product_o(mul_product)
    );

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: the driver pushes the expected
// write-back of each accepted instruction; an independent monitor pops and
// compares whenever the DUT strobes write.
module tb_alu_exec_stage;

    localparam logic [2:0] T_ADD = 3'd0, T_SUB = 3'd1, T_AND = 3'd2, T_OR = 3'd3,
                           T_XOR = 3'd4, T_SHL = 3'd5, T_MUL = 3'd6, T_PASS = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  opcode;
    logic [2:0]  dst, srcA, srcB;
    logic [2:0]  rdAddrA, rdAddrB;
    logic [15:0] rdDataA, rdDataB;
    logic        write;
    logic [2:0]  wrAddr;
    logic [15:0] wrData;
    logic        busy, zero, carry;

    always #5 clk = ~clk;

    alu_exec_stage dut (
        .clk        (clk),
        .rst        (rst),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .opcode     (opcode),
        .dst        (dst),
        .srcA       (srcA),
        .srcB       (srcB),
        .rdAddrA    (rdAddrA),
        .rdAddrB    (rdAddrB),
        .rdDataA    (rdDataA),
        .rdDataB    (rdDataB),
        .write      (write),
        .wrAddr     (wrAddr),
        .wrData     (wrData),
        .busy       (busy),
        .zero       (zero),
        .carry      (carry)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External register file: 4 backed registers, addresses 4..7 read 0 and drop writes.
    logic [15:0] rf [4];
    logic        ld_en = 1'b0;
    logic [1:0]  ld_addr = '0;
    logic [15:0] ld_data = '0;
    always @(posedge clk) begin
        if (ld_en) rf[ld_addr] <= ld_data;
        else if (write && wrAddr < 3'd4) rf[wrAddr[1:0]] <= wrData;
    end
    assign rdDataA = (rdAddrA < 3'd4) ? rf[rdAddrA[1:0]] : 16'h0000;
    assign rdDataB = (rdAddrB < 3'd4) ? rf[rdAddrB[1:0]] : 16'h0000;

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] data;
        bit          z;
        bit          c;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] mdl [4];
    int          passed = 0;
    int          total = 0;
    int          issued = 0;
    int          retired = 0;
    int          aborted = 0;
    int          ready_viol = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Architectural result of one instruction, straight from the opcode table.
    function automatic void ref_model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                      output logic [15:0] r, output bit c);
        int unsigned ua = a;
        int unsigned ub = b;
        int unsigned full;
        c = 1'b0;
        case (op)
            T_ADD:  begin full = ua + ub; r = 16'(full); c = (full > 32'hFFFF); end
            T_SUB:  begin r = 16'(ua - ub); c = (ua < ub); end
            T_AND:  r = a & b;
            T_OR:   r = a | b;
            T_XOR:  r = a ^ b;
            T_SHL:  r = 16'(ua << (ub % 16));
            T_MUL:  r = 16'(ua * ub);
            default: r = a;
        endcase
    endfunction

    task automatic preload(input int idx, input logic [15:0] val);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = 2'(idx);
        ld_data = val;
        mdl[idx] = val;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (issued != retired + aborted && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (issued != retired + aborted) begin
            total++;
            $display("FAIL wait_idle: %0d outstanding, expected 0", issued - retired - aborted);
        end
        @(negedge clk);
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] d, input logic [2:0] a,
                         input logic [2:0] b, input bit exp_wb);
        int guard = 0;
        logic [15:0] va, vb, r;
        bit c;
        exp_t e;
        @(negedge clk);
        opcode = op; dst = d; srcA = a; srcB = b;
        instr_valid = 1'b1;
        while (!instr_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!instr_ready) begin
            total++;
            $display("FAIL accept_timeout: ready=%0d, expected 1", instr_ready);
            instr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        // Fields change while busy; the block must hold its latched copy.
        opcode = 3'($urandom); dst = 3'($urandom); srcA = 3'($urandom); srcB = 3'($urandom);
        va = (a < 3'd4) ? mdl[a[1:0]] : 16'h0000;
        vb = (b < 3'd4) ? mdl[b[1:0]] : 16'h0000;
        ref_model(op, va, vb, r, c);
        if (exp_wb) begin
            e.addr = d; e.data = r; e.z = (r == 16'h0000); e.c = c;
            e.cyc  = cyc + ((op == T_MUL) ? 18 : 2);
            sb_q.push_back(e);
            if (d < 3'd4) mdl[d[1:0]] = r;
        end
        issued++;
    endtask

    // Monitor: compare every write-back against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && write) begin
                $display("WB cyc=%0d r%0d <= 0x%04h zero=%0d carry=%0d", cyc, wrAddr, wrData, zero, carry);
                if (sb_q.size() == 0) begin
                    check("unexpected_write", 32'(1), 32'(0));
                end else begin
                    e = sb_q.pop_front();
                    check("wrAddr", 32'(wrAddr), 32'(e.addr));
                    check("wrData", 32'(wrData), 32'(e.data));
                    check("zero",   32'(zero),   32'(e.z));
                    check("carry",  32'(carry),  32'(e.c));
                    check("latency_cycle", 32'(cyc), 32'(e.cyc));
                    retired++;
                end
            end
            if (!rst && instr_ready && issued != retired + aborted) ready_viol++;
        end
    end

    initial begin
        logic [15:0] pick [5];
        rst = 1'b1; instr_valid = 1'b0; opcode = '0; dst = '0; srcA = '0; srcB = '0;
        for (int i = 0; i < 4; i++) preload(i, 16'h0000);
        check("ready_during_rst", 32'(instr_ready), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_write",   32'(write),   32'(0));
        check("rst_wrAddr",  32'(wrAddr),  32'(0));
        check("rst_wrData",  32'(wrData),  32'(0));
        check("rst_busy",    32'(busy),    32'(0));
        check("rst_zero",    32'(zero),    32'(0));
        check("rst_carry",   32'(carry),   32'(0));
        check("rst_rdAddrA", 32'(rdAddrA), 32'(0));
        check("rst_ready",   32'(instr_ready), 32'(1));

        // Directed cases.
        preload(1, 16'h0003); preload(2, 16'h0005);
        issue(T_ADD, 3'd3, 3'd1, 3'd2, 1'b1);
        wait_idle();
        preload(1, 16'hFFFF); preload(2, 16'h0001);
        issue(T_ADD, 3'd0, 3'd1, 3'd2, 1'b1);
        wait_idle();
        preload(1, 16'h0002); preload(2, 16'h0005);
        issue(T_SUB, 3'd0, 3'd1, 3'd2, 1'b1);
        wait_idle();
        preload(1, 16'h0012); preload(2, 16'h0034);
        issue(T_MUL, 3'd3, 3'd1, 3'd2, 1'b1);
        wait_idle();
        preload(1, 16'h0055); preload(2, 16'h0007);
        issue(T_PASS, 3'd1, 3'd2, 3'd0, 1'b1);
        issue(T_ADD, 3'd2, 3'd1, 3'd1, 1'b1);
        wait_idle();
        preload(1, 16'h8001); preload(2, 16'h0001);
        issue(T_SHL, 3'd0, 3'd1, 3'd2, 1'b1);
        issue(T_ADD, 3'd3, 3'd1, 3'd5, 1'b1);
        issue(T_ADD, 3'd6, 3'd1, 3'd2, 1'b1);
        wait_idle();

        // Reset in the middle of a multiply: no write, IDLE after one edge.
        preload(1, 16'h1234); preload(2, 16'h00FF);
        issue(T_MUL, 3'd2, 3'd1, 3'd2, 1'b0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        aborted = issued - retired;
        check("midmul_ready_in_rst", 32'(instr_ready), 32'(0));
        @(negedge clk);
        check("midmul_busy",   32'(busy),   32'(0));
        check("midmul_write",  32'(write),  32'(0));
        check("midmul_wrData", 32'(wrData), 32'(0));
        rst = 1'b0;
        @(negedge clk);
        check("midmul_ready_after", 32'(instr_ready), 32'(1));
        repeat (25) @(negedge clk);

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                wait_idle();
                pick[0] = 16'h0000; pick[1] = 16'hFFFF; pick[2] = 16'h8000;
                pick[3] = 16'h0001; pick[4] = 16'($urandom);
                preload(int'($urandom_range(0, 3)), pick[$urandom_range(0, 4)]);
            end
            issue(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'b1);
        end
        wait_idle();

        check("ready_low_while_busy", 32'(ready_viol), 32'(0));
        check("scoreboard_empty", 32'(sb_q.size()), 32'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
